gpu_useq: RTL and testbench

GPU_USEQ -- requirements
Module: gpu_useq

---
 rtl/gpu_useq_pkg.sv | 39 +++
 rtl/gpu_useq_ucode_rom.sv | 33 +++
 rtl/gpu_useq.sv | 163 ++++++++++++++++
 tb/tb_gpu_useq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/gpu_useq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_useq_pkg
// Description : Shared definitions for the GPU microsequencer. This package
//               holds the microinstruction width, the opcode and operand
//               field ranges, the opcode values, the sequencer state encoding,
//               and a helper function that packs a microinstruction.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_useq_pkg;

  // Microinstruction layout: [15:8] opcode, [7:0] operand (branch target)
  localparam int GPU_UOP_SZ = 16;
  localparam int OP_MSB     = 15;
  localparam int OP_LSB     = 8;
  localparam int ARG_MSB    = 7;
  localparam int ARG_LSB    = 0;

  localparam logic [7:0] OP_GNOP      = 8'h00;
  localparam logic [7:0] OP_GJZ       = 8'h01;
  localparam logic [7:0] OP_GJNZ      = 8'h02;
  localparam logic [7:0] OP_GGOTO     = 8'h03;
  localparam logic [7:0] OP_GRVMEM    = 8'h04;
  localparam logic [7:0] OP_GWFBUFFER = 8'h05;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_VMEM_WAIT = 2'd2,
    ST_FB_WAIT   = 2'd3
  } state_e;

  function automatic logic [GPU_UOP_SZ-1:0] mk_uop(input logic [7:0] op,
                                                   input logic [7:0] arg);
    return {op, arg};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_useq_ucode_rom.sv
`default_nettype none
// ============================================================================
// Module      : gpu_ucode_rom
// Description : Combinational microcode ROM for the GPU microsequencer.
//               Ports:
//                 iAddr - microprogram address (8 bits)
//                 oUop  - microinstruction at iAddr, valid in the same cycle
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_ucode_rom
  import gpu_useq_pkg::*;
(
  input  logic [7:0]            iAddr,
  output logic [GPU_UOP_SZ-1:0] oUop
);

  // Sparse program; every address not listed is a gnop. Address 3 holds an
  // undefined opcode, which the sequencer executes as a gnop.
  always_comb begin
    oUop = mk_uop(OP_GNOP, 8'd0);
    case (iAddr)
      8'd3:    oUop = mk_uop(8'hAA, 8'h00);
      8'd6:    oUop = mk_uop(OP_GRVMEM, 8'd0);
      8'd15:   oUop = mk_uop(OP_GWFBUFFER, 8'd0);
      8'd20:   oUop = mk_uop(OP_GJZ, 8'd40);
      8'd40:   oUop = mk_uop(OP_GGOTO, 8'd60);
      8'd62:   oUop = mk_uop(OP_GJNZ, 8'd5);
      default: oUop = mk_uop(OP_GNOP, 8'd0);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/gpu_useq.sv
`default_nettype none
// ============================================================================
// Module      : gpu_useq
// Description : GPU microsequencer. Steps a microprogram held in
//               gpu_ucode_rom, one uop per cycle, and stalls on VRAM reads
//               and framebuffer writes.
//               Ports:
//                 iClock, iReset - clock, asynchronous active-high reset
//                 iEnable        - run microcode when 1
//                 iZero          - datapath zero flag used by gjz/gjnz
//                 iVmemAck       - VRAM grant/data-valid
//                 iFbReady       - framebuffer can accept a write
//                 oUop, oPc      - current microinstruction and its address
//                 oExec          - oUop retires this cycle
//                 oVmemReq       - VRAM read request (level)
//                 oFbWrite       - framebuffer write strobe
//                 oBusy          - sequencer not idle
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_useq
  import gpu_useq_pkg::*;
(
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iEnable,
  input  logic                  iZero,
  input  logic                  iVmemAck,
  input  logic                  iFbReady,
  output logic [GPU_UOP_SZ-1:0] oUop,
  output logic [7:0]            oPc,
  output logic                  oExec,
  output logic                  oVmemReq,
  output logic                  oFbWrite,
  output logic                  oBusy
);

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  // Set when iEnable drops while a memory op is outstanding, so the op
  // completes and the sequencer still lands in IDLE even if iEnable rises again.
  logic        drain_q, drain_d;

  logic [7:0]  w_opcode;
  logic [7:0]  w_target;
  logic [7:0]  w_pc_inc;
  logic        w_exec;
  logic        w_vmem_req;
  logic        w_fb_write;

  gpu_ucode_rom u_rom (
    .iAddr (pc_q),
    .oUop  (oUop)
  );

  assign w_opcode = oUop[OP_MSB:OP_LSB];
  assign w_target = oUop[ARG_MSB:ARG_LSB];
  assign w_pc_inc = pc_q + 8'd1;  // wraps 255 -> 0

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drain_d    = drain_q;
    w_exec     = 1'b0;
    w_vmem_req = 1'b0;
    w_fb_write = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pc_d    = 8'd0;
        drain_d = 1'b0;
        if (iEnable) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (!iEnable) begin
          // Current uop is abandoned before it issues anything.
          state_d = ST_IDLE;
          pc_d    = 8'd0;
        end else begin
          case (w_opcode)
            OP_GJZ: begin
              w_exec = 1'b1;
              pc_d   = iZero ? w_target : w_pc_inc;
            end
            OP_GJNZ: begin
              w_exec = 1'b1;
              pc_d   = iZero ? w_pc_inc : w_target;
            end
            OP_GGOTO: begin
              w_exec = 1'b1;
              pc_d   = w_target;
            end
            OP_GRVMEM: begin
              w_vmem_req = 1'b1;
              if (iVmemAck) begin
                w_exec = 1'b1;
                pc_d   = w_pc_inc;
              end else begin
                state_d = ST_VMEM_WAIT;
              end
            end
            OP_GWFBUFFER: begin
              if (iFbReady) begin
                w_fb_write = 1'b1;
                w_exec     = 1'b1;
                pc_d       = w_pc_inc;
              end else begin
                state_d = ST_FB_WAIT;
              end
            end
            default: begin
              w_exec = 1'b1;
              pc_d   = w_pc_inc;
            end
          endcase
        end
      end

      ST_VMEM_WAIT, ST_FB_WAIT: begin
        if (!iEnable) drain_d = 1'b1;
        w_vmem_req = (state_q == ST_VMEM_WAIT);
        if ((state_q == ST_VMEM_WAIT) ? iVmemAck : iFbReady) begin
          w_exec     = 1'b1;
          w_fb_write = (state_q == ST_FB_WAIT);
          if (drain_q || !iEnable) begin
            state_d = ST_IDLE;
            pc_d    = 8'd0;
            drain_d = 1'b0;
          end else begin
            state_d = ST_RUN;
            pc_d    = w_pc_inc;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        pc_d    = 8'd0;
        drain_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      pc_q    <= 8'd0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
    end
  end

  assign oPc      = pc_q;
  assign oExec    = w_exec;
  assign oVmemReq = w_vmem_req;
  assign oFbWrite = w_fb_write;
  assign oBusy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gpu_useq.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_useq
// Description : Self-checking bench for gpu_useq. A table of per-cycle
//               vectors covers straight-line flow, VRAM and framebuffer
//               stalls and taken branches; hand-written sequences cover the
//               not-taken branch, PC wrap, enable drop and reset mid-wait.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_useq;
  import gpu_useq_pkg::*;

  logic                  iClock = 1'b0;
  logic                  iReset = 1'b1;
  logic                  iEnable = 1'b0;
  logic                  iZero = 1'b0;
  logic                  iVmemAck = 1'b0;
  logic                  iFbReady = 1'b0;
  logic [GPU_UOP_SZ-1:0] oUop;
  logic [7:0]            oPc;
  logic                  oExec;
  logic                  oVmemReq;
  logic                  oFbWrite;
  logic                  oBusy;

  int n_cmp = 0;
  int n_bad = 0;

  gpu_useq dut (
    .iClock   (iClock),
    .iReset   (iReset),
    .iEnable  (iEnable),
    .iZero    (iZero),
    .iVmemAck (iVmemAck),
    .iFbReady (iFbReady),
    .oUop     (oUop),
    .oPc      (oPc),
    .oExec    (oExec),
    .oVmemReq (oVmemReq),
    .oFbWrite (oFbWrite),
    .oBusy    (oBusy)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    bit       en, z, va, fr;
    bit [7:0] pc;
    bit       ex, vr, fw, bs;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit en, bit z, bit va, bit fr, bit [7:0] pc,
                             bit ex, bit vr, bit fw, bit bs);
    vec_t r;
    r.en = en; r.z = z; r.va = va; r.fr = fr; r.pc = pc;
    r.ex = ex; r.vr = vr; r.fw = fw; r.bs = bs;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input bit [7:0] pc, input bit ex,
                         input bit vr, input bit fw, input bit bs);
    chk({tag, ".pc"},   int'(oPc), int'(pc));
    chk({tag, ".exec"}, int'(oExec), int'(ex));
    chk({tag, ".vreq"}, int'(oVmemReq), int'(vr));
    chk({tag, ".fbw"},  int'(oFbWrite), int'(fw));
    chk({tag, ".busy"}, int'(oBusy), int'(bs));
  endtask

  task automatic edge1();
    @(posedge iClock);
    #1;
  endtask

  task automatic drive(input bit en, input bit z, input bit va, input bit fr);
    iEnable = en; iZero = z; iVmemAck = va; iFbReady = fr;
    #3;
  endtask

  task automatic cyc(input bit en, input bit z, input bit va, input bit fr);
    edge1();
    drive(en, z, va, fr);
  endtask

  // Advance until the current cycle presents oPc == target; returns just
  // after the edge, before this cycle's inputs are driven.
  task automatic run_to(input bit [7:0] target);
    int n = 0;
    edge1();
    while (oPc != target && n < 400) begin
      drive(1, 0, 1, 1);
      edge1();
      n++;
    end
    chk("run_to", int'(oPc), int'(target));
  endtask

  initial begin
    // Vector table, one record per clock cycle after reset release
    vecs.push_back(v(1,0,1,1, 8'd0, 0,0,0,0));             // IDLE cycle
    for (int p = 0; p < 6; p++)
      vecs.push_back(v(1,0,1,1, 8'(p), 1,0,0,1));          // nops (3 = unknown op)
    vecs.push_back(v(1,0,0,1, 8'd6, 0,1,0,1));             // grvmem issue, no ack
    vecs.push_back(v(1,0,0,1, 8'd6, 0,1,0,1));
    vecs.push_back(v(1,0,0,1, 8'd6, 0,1,0,1));
    vecs.push_back(v(1,0,1,1, 8'd6, 1,1,0,1));             // ack -> retire
    for (int p = 7; p < 15; p++)
      vecs.push_back(v(1,0,1,1, 8'(p), 1,0,0,1));
    vecs.push_back(v(1,0,1,0, 8'd15, 0,0,0,1));            // gwfbuffer, not ready
    vecs.push_back(v(1,0,1,0, 8'd15, 0,0,0,1));
    vecs.push_back(v(1,0,1,1, 8'd15, 1,0,1,1));            // ready -> one strobe
    for (int p = 16; p < 20; p++)
      vecs.push_back(v(1,0,1,1, 8'(p), 1,0,0,1));
    vecs.push_back(v(1,1,1,1, 8'd20, 1,0,0,1));            // gjz taken -> 40
    vecs.push_back(v(1,0,1,1, 8'd40, 1,0,0,1));            // ggoto 60
    vecs.push_back(v(1,0,1,1, 8'd60, 1,0,0,1));
    vecs.push_back(v(1,0,1,1, 8'd61, 1,0,0,1));
    vecs.push_back(v(1,0,1,1, 8'd62, 1,0,0,1));            // gjnz taken -> 5
    vecs.push_back(v(1,0,1,1, 8'd5, 1,0,0,1));
    vecs.push_back(v(1,0,1,1, 8'd6, 1,1,0,1));             // zero-latency ack
    vecs.push_back(v(1,0,1,1, 8'd7, 1,0,0,1));

    // Reset state
    repeat (2) @(posedge iClock);
    #4;
    chk_all("reset", 8'd0, 0, 0, 0, 0);
    iReset = 1'b0;

    foreach (vecs[i]) begin
      cyc(vecs[i].en, vecs[i].z, vecs[i].va, vecs[i].fr);
      chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ex, vecs[i].vr,
              vecs[i].fw, vecs[i].bs);
    end

    // gjnz not taken, then PC wrap 255 -> 0
    run_to(8'd62);
    drive(1, 1, 1, 1);
    chk("gjnz_nt.exec", int'(oExec), 1);
    cyc(1, 0, 1, 1);
    chk("gjnz_nt.pc", int'(oPc), 63);
    run_to(8'd255);
    drive(1, 0, 1, 1);
    chk("wrap.exec", int'(oExec), 1);
    cyc(1, 0, 1, 1);
    chk("wrap.pc", int'(oPc), 0);

    // Enable drop in RUN: current uop does not retire, then IDLE
    cyc(0, 0, 1, 1);
    chk_all("endrop_run", 8'd1, 0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    chk_all("endrop_idle", 8'd0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1);
    chk_all("endrop_idle2", 8'd0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1);
    chk_all("endrop_run0", 8'd0, 1, 0, 0, 1);

    // Enable drop during VMEM_WAIT; ack arrives 2 cycles later with
    // enable back high, yet the sequencer must still pass through IDLE
    run_to(8'd6);
    drive(1, 0, 0, 1);
    chk_all("drain_issue", 8'd6, 0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    chk_all("drain_w1", 8'd6, 0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    chk_all("drain_w2", 8'd6, 0, 1, 0, 1);
    cyc(1, 0, 1, 1);
    chk_all("drain_ack", 8'd6, 1, 1, 0, 1);
    cyc(1, 0, 1, 1);
    chk_all("drain_idle", 8'd0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1);
    chk_all("drain_run0", 8'd0, 1, 0, 0, 1);

    // Reset asserted during VMEM_WAIT drops the request immediately
    run_to(8'd6);
    drive(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk_all("rstw_wait", 8'd6, 0, 1, 0, 1);
    iReset = 1'b1;
    #1;
    chk_all("rstw_now", 8'd0, 0, 0, 0, 0);
    edge1();
    iReset = 1'b0;
    drive(1, 0, 1, 1);
    chk_all("rstw_idle", 8'd0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1);
    chk_all("rstw_run0", 8'd0, 1, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
